// File: rtl/tap_pkg.sv
// Shared types and constants for the tap_v2 JTAG TAP.
// TAP and loader state enums, opcodes and DR lengths.
package tap_pkg;

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR,
    ST_PA_DR, ST_EX2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR,
    ST_PA_IR, ST_EX2_IR, ST_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    LD_DATA, LD_TAG, LD_DONE
  } ld_state_e;

  localparam int OP_EXTEST     = 0;
  localparam int OP_IDCODE     = 1;
  localparam int OP_SAMPLE     = 2;
  localparam int OP_INTEST     = 3;
  localparam int OP_PROGRAM    = 4;
  localparam int OP_USERCODE   = 5;
  localparam int OP_CFG_STATUS = 6;

  localparam int LEN_BYPASS = 1;
  localparam int LEN_IDCODE = 32;
  localparam int LEN_STATUS = 18;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tap_v2_if.sv
// Serial JTAG data/mode lines between pins and the TAP.
// tck and trst stay as plain ports on the TAP.
interface tap_v2_if;
  logic tms;
  logic tdi;
  logic tdo;

  modport master (
    output tms,
    output tdi,
    input  tdo
  );

  modport slave (
    input  tms,
    input  tdi,
    output tdo
  );
endinterface

// File: rtl/tap_ctrl.sv
// IEEE 1149.1 16-state TAP controller.
// Emits the current state plus one-hot action strobes.
module tap_ctrl
  import tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       tlr,
  output logic       idle
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_q <= ST_TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:    state_d = tms ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = tms ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  state_d = tms ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: state_d = tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = tms ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  state_d = tms ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: state_d = tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = tms ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase
  end

  always_comb begin
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    tlr        = 1'b0;
    idle       = 1'b0;
    unique case (state_q)
      ST_CAP_DR: capture_dr = 1'b1;
      ST_SH_DR:  shift_dr   = 1'b1;
      ST_UPD_DR: update_dr  = 1'b1;
      ST_CAP_IR: capture_ir = 1'b1;
      ST_SH_IR:  shift_ir   = 1'b1;
      ST_UPD_IR: update_ir  = 1'b1;
      ST_TLR:    tlr        = 1'b1;
      ST_RTI:    idle       = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/tap_v2.sv
// JTAG TAP with bypass/ID/user/boundary/status DRs
// and a framed config loader active in Run-Test/Idle.
module tap_v2
  import tap_pkg::*;
#(
  parameter int          IR_LEN       = 4,
  parameter int          PINS_IN      = 4,
  parameter int          PINS_OUT     = 4,
  parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
  parameter logic [31:0] USERCODE_VAL = 32'h0000_0000,
  parameter int          CFG_WIDTH    = 32,
  parameter int          TAG_LEN      = 16,
  parameter logic [TAG_LEN-1:0] TAG_SEND = 16'hFAB2,
  parameter logic [TAG_LEN-1:0] TAG_END  = 16'hFAB3
) (
  input  logic                 tck,
  input  logic                 trst,
  tap_v2_if.slave              jtag,
  input  logic [PINS_IN-1:0]   pins_in,
  output logic [PINS_OUT-1:0]  pins_out,
  output logic [PINS_IN-1:0]   logic_pins_in,
  input  logic [PINS_OUT-1:0]  logic_pins_out,
  output logic                 active,
  output logic [CFG_WIDTH-1:0] config_data,
  output logic                 config_strobe,
  output logic                 config_done,
  output logic                 config_error
);

  localparam int BSW = PINS_OUT + PINS_IN;
  localparam int DRW = max2(BSW, LEN_IDCODE);
  localparam int DLW = $clog2(DRW);
  localparam int CW  = $clog2(max2(CFG_WIDTH, TAG_LEN) + 1);

  tap_state_e state;
  logic capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;
  logic tlr, idle;

  tap_ctrl u_ctrl (
    .tck        (tck),
    .trst       (trst),
    .tms        (jtag.tms),
    .state      (state),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .tlr        (tlr),
    .idle       (idle)
  );

  logic [IR_LEN-1:0]    ir_q, ir_d;
  logic [IR_LEN-1:0]    ir_sr_q, ir_sr_d;
  logic [DRW-1:0]       dr_sr_q, dr_sr_d;
  logic [PINS_IN-1:0]   upd_in_q, upd_in_d;
  logic [PINS_OUT-1:0]  upd_out_q, upd_out_d;
  logic [CFG_WIDTH-1:0] word_q, word_d;
  logic [TAG_LEN-2:0]   tag_q, tag_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  ld_state_e            ld_q, ld_d;
  logic [CFG_WIDTH-1:0] data_q, data_d;
  logic                 strobe_q, strobe_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [15:0]          wc_q, wc_d;
  logic                 tdo_q, tdo_d;

  logic is_ext, is_int, is_spl, is_prg;
  logic is_id, is_usr, is_sts, is_bs;

  assign is_ext = (ir_q == IR_LEN'(OP_EXTEST));
  assign is_id  = (ir_q == IR_LEN'(OP_IDCODE));
  assign is_spl = (ir_q == IR_LEN'(OP_SAMPLE));
  assign is_int = (ir_q == IR_LEN'(OP_INTEST));
  assign is_prg = (ir_q == IR_LEN'(OP_PROGRAM));
  assign is_usr = (ir_q == IR_LEN'(OP_USERCODE));
  assign is_sts = (ir_q == IR_LEN'(OP_CFG_STATUS));
  assign is_bs  = is_ext | is_int | is_spl;

  logic [DLW-1:0] dr_msb;
  logic [DRW-1:0] dr_cap;
  logic [DRW-1:0] dr_shift;
  logic [TAG_LEN-1:0] tag_nxt;
  logic armed;

  assign armed = is_prg & idle;

  always_comb begin
    dr_msb = DLW'(LEN_BYPASS - 1);
    dr_cap = '0;
    unique case (1'b1)
      is_id: begin
        dr_msb = DLW'(LEN_IDCODE - 1);
        dr_cap = DRW'(IDCODE_VAL);
      end
      is_usr: begin
        dr_msb = DLW'(LEN_IDCODE - 1);
        dr_cap = DRW'(USERCODE_VAL);
      end
      is_sts: begin
        dr_msb = DLW'(LEN_STATUS - 1);
        dr_cap = DRW'({err_q, done_q, wc_q});
      end
      is_bs: begin
        dr_msb = DLW'(BSW - 1);
        dr_cap = DRW'({logic_pins_out, pins_in});
      end
      default: ;
    endcase
  end

  // Bits above the selected length stay 0 from capture.
  always_comb begin
    dr_shift = dr_sr_q >> 1;
    dr_shift[dr_msb] = jtag.tdi;
  end

  always_comb begin
    ir_d      = ir_q;
    ir_sr_d   = ir_sr_q;
    dr_sr_d   = dr_sr_q;
    upd_in_d  = upd_in_q;
    upd_out_d = upd_out_q;
    word_d    = word_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    ld_d      = ld_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    done_d    = done_q;
    err_d     = err_q;
    wc_d      = wc_q;
    tag_nxt   = {tag_q, jtag.tdi};

    if (capture_ir) ir_sr_d = IR_LEN'(1);
    if (shift_ir)   ir_sr_d = {jtag.tdi, ir_sr_q[IR_LEN-1:1]};
    if (update_ir)  ir_d    = ir_sr_q;
    if (tlr)        ir_d    = IR_LEN'(OP_IDCODE);

    if (capture_dr) dr_sr_d = dr_cap;
    if (shift_dr)   dr_sr_d = dr_shift;
    if (update_dr && is_bs) begin
      upd_in_d  = dr_sr_q[PINS_IN-1:0];
      upd_out_d = dr_sr_q[BSW-1:PINS_IN];
    end

    if (armed) begin
      case (ld_q)
        LD_DATA: begin
          word_d = {word_q[CFG_WIDTH-2:0], jtag.tdi};
          if (cnt_q == CW'(CFG_WIDTH - 1)) begin
            ld_d  = LD_TAG;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        LD_TAG: begin
          tag_d = tag_nxt[TAG_LEN-2:0];
          if (cnt_q == CW'(TAG_LEN - 1)) begin
            cnt_d = '0;
            if (tag_nxt == TAG_SEND) begin
              data_d   = word_q;
              strobe_d = 1'b1;
              wc_d     = (wc_q == 16'hFFFF) ? wc_q
                                            : wc_q + 16'd1;
              ld_d     = LD_DATA;
            end else if (tag_nxt == TAG_END) begin
              done_d = 1'b1;
              ld_d   = LD_DONE;
            end else begin
              err_d = 1'b1;
              ld_d  = LD_DONE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end else if (ld_q != LD_DONE) begin
      ld_d  = LD_DATA;
      cnt_d = '0;
    end

    if (update_ir && ir_sr_q == IR_LEN'(OP_PROGRAM)) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      wc_d   = '0;
      ld_d   = LD_DATA;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_q      <= IR_LEN'(OP_IDCODE);
      ir_sr_q   <= '0;
      dr_sr_q   <= '0;
      upd_in_q  <= '0;
      upd_out_q <= '0;
      word_q    <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      ld_q      <= LD_DATA;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wc_q      <= '0;
    end else begin
      ir_q      <= ir_d;
      ir_sr_q   <= ir_sr_d;
      dr_sr_q   <= dr_sr_d;
      upd_in_q  <= upd_in_d;
      upd_out_q <= upd_out_d;
      word_q    <= word_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      ld_q      <= ld_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wc_q      <= wc_d;
    end
  end

  always_comb begin
    tdo_d = 1'b0;
    unique case (state)
      ST_SH_IR: tdo_d = ir_sr_q[0];
      ST_SH_DR: tdo_d = dr_sr_q[0];
      default: ;
    endcase
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) tdo_q <= 1'b0;
    else       tdo_q <= tdo_d;
  end

  assign jtag.tdo      = tdo_q;
  assign pins_out      = (is_ext | is_int) ? upd_out_q
                                           : logic_pins_out;
  assign logic_pins_in = is_int ? upd_in_q : pins_in;
  assign active        = is_ext | is_int | is_prg;
  assign config_data   = data_q;
  assign config_strobe = strobe_q;
  assign config_done   = done_q;
  assign config_error  = err_q;

endmodule

// File: tb/tb_tap_v2.sv
// Randomized self-checking bench for tap_v2.
// Reference model tracks loader status per frame.
module tb_tap_v2;

  localparam logic [31:0] IDC  = 32'h1000_0001;
  localparam logic [15:0] TSND = 16'hFAB2;
  localparam logic [15:0] TEND = 16'hFAB3;

  logic        tck = 1'b0;
  logic        trst;
  logic [3:0]  pins_in, pins_out;
  logic [3:0]  logic_pins_in, logic_pins_out;
  logic        active;
  logic [31:0] config_data;
  logic        config_strobe, config_done, config_error;

  tap_v2_if jtag ();

  tap_v2 dut (
    .tck            (tck),
    .trst           (trst),
    .jtag           (jtag),
    .pins_in        (pins_in),
    .pins_out       (pins_out),
    .logic_pins_in  (logic_pins_in),
    .logic_pins_out (logic_pins_out),
    .active         (active),
    .config_data    (config_data),
    .config_strobe  (config_strobe),
    .config_done    (config_done),
    .config_error   (config_error)
  );

  always #5 tck = ~tck;

  int n_chk  = 0;
  int n_pass = 0;
  int strobes = 0;

  always @(negedge tck) if (config_strobe) strobes++;

  // loader reference state
  logic [31:0] m_data;
  logic [15:0] m_wc;
  logic        m_done, m_err, m_live;
  int          m_strobes;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick(input logic m, input logic d);
    jtag.tms = m;
    jtag.tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic shift(input int n, input logic [63:0] din,
                       output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = jtag.tdo;
      tick(i == n - 1, din[i]);
    end
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din,
                         output logic [63:0] dout);
    tick(1, 0); tick(0, 0); tick(0, 0);
    shift(n, din, dout);
    tick(1, 0); tick(0, 0);
  endtask

  task automatic scan_ir(input logic [3:0] op,
                         output logic [3:0] cap);
    logic [63:0] d;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    shift(4, {60'd0, op}, d);
    tick(1, 0); tick(0, 0);
    cap = d[3:0];
    if (op != 4'h4) m_live = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tick(0, v[i]);
  endtask

  task automatic arm();
    logic [3:0] c;
    scan_ir(4'h4, c);
    m_wc = 0; m_done = 0; m_err = 0; m_live = 1;
    chk("arm_done", config_done, 0);
    chk("arm_err", config_error, 0);
    chk("arm_active", active, 1);
  endtask

  task automatic frame(input logic [31:0] w,
                       input logic [15:0] t);
    logic snd;
    snd = m_live && (t == TSND);
    send_bits({32'd0, w}, 32);
    send_bits({48'd0, t}, 16);
    chk("strobe_now", config_strobe, snd);
    if (m_live) begin
      if (t == TSND) begin
        m_data = w;
        if (m_wc != 16'hFFFF) m_wc++;
        m_strobes++;
      end else if (t == TEND) begin
        m_done = 1; m_live = 0;
      end else begin
        m_err = 1; m_live = 0;
      end
    end
    chk("cfg_data", config_data, m_data);
    chk("cfg_done", config_done, m_done);
    chk("cfg_err", config_error, m_err);
    chk("strobe_cnt", strobes, m_strobes);
  endtask

  task automatic read_status();
    logic [3:0] c;
    logic [63:0] d;
    scan_ir(4'h6, c);
    scan_dr(18, 0, d);
    chk("status", d, {46'd0, m_err, m_done, m_wc});
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_tdo"}, jtag.tdo, 0);
    chk({tag, "_data"}, config_data, 0);
    chk({tag, "_stb"}, config_strobe, 0);
    chk({tag, "_done"}, config_done, 0);
    chk({tag, "_err"}, config_error, 0);
    chk({tag, "_act"}, active, 0);
    chk({tag, "_pout"}, pins_out, logic_pins_out);
    chk({tag, "_lpin"}, logic_pins_in, pins_in);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  c;
    logic [63:0] d;
    logic [15:0] r16, bad;
    logic [7:0]  v8;
    logic [31:0] w;
    m_data = 0; m_wc = 0; m_done = 0; m_err = 0;
    m_live = 0; m_strobes = 0;
    trst = 0; jtag.tms = 1; jtag.tdi = 0;
    pins_in = 4'b0110; logic_pins_out = 4'b1001;
    #12;
    reset_checks("rst");
    trst = 1;
    @(negedge tck); #1;
    tick(0, 0);

    scan_dr(32, 0, d);
    chk("idcode", d, {32'd0, IDC});
    scan_ir(4'hF, c);
    chk("ir_cap", c, 4'b0001);
    scan_dr(9, {55'd0, 1'b0, 8'b10110100}, d);
    chk("bypass", d, {55'd0, 8'b10110100, 1'b0});
    r16 = 16'($urandom);
    scan_dr(17, {48'd0, r16}, d);
    chk("bypass_rnd", d, {47'd0, r16, 1'b0});
    scan_ir(4'h5, c);
    scan_dr(32, 0, d);
    chk("usercode", d, 0);

    pins_in = 4'b0100; logic_pins_out = 4'b0101;
    scan_ir(4'h2, c);
    chk("spl_active", active, 0);
    scan_dr(8, 64'hA0, d);
    chk("spl_cap", d, 64'h54);
    chk("spl_pout", pins_out, logic_pins_out);
    scan_ir(4'h0, c);
    scan_dr(8, 64'hA0, d);
    chk("ext_cap", d, {56'd0, logic_pins_out, pins_in});
    chk("ext_pout", pins_out, 4'hA);
    chk("ext_lpin", logic_pins_in, 4'b0100);
    chk("ext_active", active, 1);
    v8 = 8'($urandom);
    pins_in = 4'($urandom); logic_pins_out = 4'($urandom);
    scan_ir(4'h3, c);
    scan_dr(8, {56'd0, v8}, d);
    chk("int_cap", d, {56'd0, logic_pins_out, pins_in});
    chk("int_pout", pins_out, v8[7:4]);
    chk("int_lpin", logic_pins_in, v8[3:0]);
    chk("int_active", active, 1);

    arm();
    frame(32'h11223344, TSND);
    frame(32'h55667788, TSND);
    frame(32'h99AABBCC, TSND);
    frame(32'hDDEEFF00, TSND);
    frame(32'h0, TEND);
    read_status();

    arm();
    frame(32'($urandom), 16'h1234);
    frame(32'($urandom), TSND);
    arm();
    read_status();

    arm();
    send_bits({32'd0, 32'($urandom)}, 20);
    tick(1, 1); tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0);
    frame(32'($urandom), TSND);

    for (int t = 0; t < 3; t++) begin
      arm();
      for (int k = 0; k < 4; k++) begin
        w = 32'($urandom);
        bad = 16'($urandom);
        if (bad == TSND || bad == TEND) bad = 16'h1234;
        case ($urandom_range(0, 5))
          4: frame(w, TEND);
          5: frame(w, bad);
          default: frame(w, TSND);
        endcase
      end
      read_status();
    end

    arm();
    frame(32'($urandom), TSND);
    send_bits({32'd0, 32'($urandom)}, 10);
    trst = 0;
    #2;
    m_data = 0; m_wc = 0; m_done = 0; m_err = 0; m_live = 0;
    reset_checks("mid");
    #2;
    trst = 1;
    @(negedge tck); #1;
    tick(0, 0);
    scan_dr(32, 0, d);
    chk("idcode2", d, {32'd0, IDC});
    scan_ir(4'h1, c);
    chk("ir_cap2", c, 4'b0001);
    read_status();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
